// File: rtl/down_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_ctrl
// Brief    : Loadable down counter with start/pause/abort control and a
//            one-cycle done pulse on expiry. Define
//            DOWN_COUNTER_CTRL_AUTO_RELOAD_EN for periodic auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
module down_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] w_next_counter;
    logic             r_done;
    logic             w_next_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_counter <= C_ZERO;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_counter <= w_next_counter;
            r_done    <= w_next_done;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_counter = r_counter;
        w_next_done    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // DONE lasts one cycle; a start seen there is treated as from IDLE
                w_next_state = ST_IDLE;
                if (!abort && !pause && start) begin
                    if (load_val != C_ZERO) begin
                        w_next_counter = load_val;
                        w_next_state   = ST_RUN;
                    end else begin
                        w_next_counter = C_ZERO;
                        w_next_done    = 1'b1;
                        w_next_state   = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_counter = C_ZERO;
                    w_next_state   = ST_IDLE;
                end else if (pause) begin
                    w_next_state = ST_PAUSE;
                end else if (r_counter > C_ONE) begin
                    w_next_counter = r_counter - C_ONE;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
                end else if (r_counter == C_ONE) begin
                    // expiry: stay in RUN showing zero for one cycle
                    w_next_counter = C_ZERO;
                    w_next_done    = 1'b1;
                end else if (load_val != C_ZERO) begin
                    w_next_counter = load_val;
                end else begin
                    w_next_state = ST_DONE;
                end
`else
                end else begin
                    w_next_counter = C_ZERO;
                    w_next_done    = 1'b1;
                    w_next_state   = ST_DONE;
                end
`endif
            end
            ST_PAUSE: begin
                if (abort) begin
                    w_next_counter = C_ZERO;
                    w_next_state   = ST_IDLE;
                end else if (!pause) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state   = ST_IDLE;
                w_next_counter = C_ZERO;
            end
        endcase
    end

    assign counter = r_counter;
    assign state   = r_state;
    assign done    = r_done;
    assign busy    = (r_state == ST_RUN) || (r_state == ST_PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_down_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_counter_ctrl
// Brief    : Scoreboard bench for down_counter_ctrl (one-shot by default,
//            auto-reload when DOWN_COUNTER_CTRL_AUTO_RELOAD_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_down_counter_ctrl;

    localparam int WIDTH = 4;
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_RUN   = 2'd1;
    localparam logic [1:0] C_PAUSE = 2'd2;
    localparam logic [1:0] C_DONE  = 2'd3;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic [1:0]       st;
        logic             dn;
        logic             bz;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] counter;
    logic [1:0]       state;
    logic             busy;
    logic             done;

    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  sb_q[$];

    down_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .load_val (load_val),
        .counter  (counter),
        .state    (state),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_val({tag, ".counter"}, 32'(counter), 32'(e.cnt));
        check_val({tag, ".state"},   32'(state),   32'(e.st));
        check_val({tag, ".done"},    32'(done),    32'(e.dn));
        check_val({tag, ".busy"},    32'(busy),    32'(e.bz));
    endtask

    // Drive one cycle of inputs, queue what the next edge must produce, then check it.
    task automatic step(input string tag, input logic s, input logic p, input logic a,
                        input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] ec,
                        input logic [1:0] es, input logic ed);
        exp_t e;
        start    = s;
        pause    = p;
        abort    = a;
        load_val = lv;
        sb_q.push_back('{cnt: ec, st: es, dn: ed, bz: (es == C_RUN) || (es == C_PAUSE)});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_outputs(tag, e);
    endtask

    initial begin
        #1 reset = 1'b1;
        #27;
        check_outputs("reset", '{cnt: '0, st: C_IDLE, dn: 1'b0, bz: 1'b0});
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

`ifndef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
        // basic countdown from 5
        step("cd5_load", 1, 0, 0, 4'd5, 4'd5, C_RUN, 0);
        step("cd5_4",    0, 0, 0, 4'd5, 4'd4, C_RUN, 0);
        step("cd5_3",    0, 0, 0, 4'd5, 4'd3, C_RUN, 0);
        step("cd5_2",    0, 0, 0, 4'd5, 4'd2, C_RUN, 0);
        step("cd5_1",    0, 0, 0, 4'd5, 4'd1, C_RUN, 0);
        step("cd5_exp",  0, 0, 0, 4'd5, 4'd0, C_DONE, 1);
        step("cd5_idle", 0, 0, 0, 4'd5, 4'd0, C_IDLE, 0);
        step("cd5_hold", 0, 0, 0, 4'd9, 4'd0, C_IDLE, 0);

        // pause holds the count, resume does not decrement
        step("pz_load",  1, 0, 0, 4'd3, 4'd3, C_RUN, 0);
        step("pz_2",     0, 0, 0, 4'd3, 4'd2, C_RUN, 0);
        for (int i = 0; i < 4; i++)
            step("pz_hold", 0, 1, 0, 4'd3, 4'd2, C_PAUSE, 0);
        step("pz_resume", 0, 0, 0, 4'd3, 4'd2, C_RUN, 0);
        step("pz_1",      0, 0, 0, 4'd3, 4'd1, C_RUN, 0);
        step("pz_exp",    0, 0, 0, 4'd3, 4'd0, C_DONE, 1);
        step("pz_idle",   0, 0, 0, 4'd3, 4'd0, C_IDLE, 0);

        // start ignored while running; start in DONE restarts
        step("rs_load",  1, 0, 0, 4'd3, 4'd3, C_RUN, 0);
        step("rs_ign",   1, 0, 0, 4'd7, 4'd2, C_RUN, 0);
        step("rs_1",     0, 0, 0, 4'd7, 4'd1, C_RUN, 0);
        step("rs_exp",   0, 0, 0, 4'd7, 4'd0, C_DONE, 1);
        step("rs_rest",  1, 0, 0, 4'd2, 4'd2, C_RUN, 0);
        step("rs_abort", 0, 0, 1, 4'd2, 4'd0, C_IDLE, 0);
`else
        // periodic reload with N=2 gives a 3-cycle period
        step("ar_load",  1, 0, 0, 4'd2, 4'd2, C_RUN, 0);
        step("ar_1",     0, 0, 0, 4'd2, 4'd1, C_RUN, 0);
        step("ar_exp0",  0, 0, 0, 4'd2, 4'd0, C_RUN, 1);
        step("ar_rl",    0, 0, 0, 4'd2, 4'd2, C_RUN, 0);
        step("ar_1b",    0, 0, 0, 4'd2, 4'd1, C_RUN, 0);
        step("ar_exp1",  0, 0, 0, 4'd2, 4'd0, C_RUN, 1);
        step("ar_rl2",   0, 0, 0, 4'd2, 4'd2, C_RUN, 0);
        step("ar_pause", 0, 1, 0, 4'd2, 4'd2, C_PAUSE, 0);
        step("ar_res",   0, 0, 0, 4'd2, 4'd2, C_RUN, 0);
        step("ar_abort", 0, 0, 1, 4'd2, 4'd0, C_IDLE, 0);
        step("ar_idle",  0, 0, 0, 4'd2, 4'd0, C_IDLE, 0);
`endif

        // abort mid-countdown from 15
        step("ab_load", 1, 0, 0, 4'd15, 4'd15, C_RUN, 0);
        for (int v = 14; v >= 9; v--)
            step("ab_dec", 0, 0, 0, 4'd15, 4'(v), C_RUN, 0);
        step("ab_abort", 0, 0, 1, 4'd15, 4'd0, C_IDLE, 0);
        step("ab_idle",  0, 0, 0, 4'd15, 4'd0, C_IDLE, 0);

        // zero load expires immediately
        step("z_start", 1, 0, 0, 4'd0, 4'd0, C_DONE, 1);
        step("z_idle",  0, 0, 0, 4'd0, 4'd0, C_IDLE, 0);
        step("z_stay",  0, 0, 0, 4'd0, 4'd0, C_IDLE, 0);

        // asynchronous reset between edges
        step("ar8_load", 1, 0, 0, 4'd8, 4'd8, C_RUN, 0);
        step("ar8_7",    0, 0, 0, 4'd8, 4'd7, C_RUN, 0);
        step("ar8_6",    0, 0, 0, 4'd8, 4'd6, C_RUN, 0);
        #2 reset = 1'b1;
        #1;
        check_outputs("async_rst", '{cnt: '0, st: C_IDLE, dn: 1'b0, bz: 1'b0});
        @(posedge clk);
        #1 reset = 1'b0;
        step("post_rst", 0, 0, 0, 4'd8, 4'd0, C_IDLE, 0);
        step("post_go",  1, 0, 0, 4'd4, 4'd4, C_RUN, 0);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
